key_event_sequencer: RTL and testbench
======================================

KEY_EVENT_SEQUENCER -- requirements
Module: key_event_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, event FIFO depth in entries (power of two, 2..16).
REQ-002 Parameter REPEAT_DELAY, default 16, ticks a key is held before the first repeat event.
REQ-003 Parameter REPEAT_RATE, default 4, ticks between subsequent repeat events (>=1).
REQ-004 sysclk  input  1  system clock; all logic on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 tick  input  1  heartbeat strobe, one sysclk cycle wide.
REQ-007 key_pulse  input  5  debounced one-shot press pulses, one bit per key 0..4.
REQ-008 key_level  input  5  debounced held level per key (1 = held).
REQ-009 evt_ready  input  1  consumer accepts the head event.
REQ-010 evt_valid  output  1  head event present (FIFO not empty).
REQ-011 evt_code  output  3  key index 0..4 of the head event.
REQ-012 evt_repeat  output  1  head event is an auto-repeat (0 = initial press).
REQ-013 fifo_count  output  clog2(DEPTH)+1  number of queued events.
REQ-014 overflow  output  1  sticky: an event was dropped; cleared by reset or ovf_clr.
REQ-015 ovf_clr  input  1  clears overflow, one cycle.

Function
REQ-016 If several key_pulse bits are set in one cycle, the lowest index is enqueued; the others are discarded and overflow is set.
REQ-017 Press latency: key_pulse in cycle N with an empty FIFO gives evt_valid=1 in cycle N+1 with evt_repeat=0.
REQ-018 The FIFO is show-ahead: evt_code/evt_repeat are valid whenever evt_valid=1; a pop occurs on evt_valid&&evt_ready.
REQ-019 A push to a full FIFO is dropped and sets overflow, unless a pop occurs in the same cycle, in which case the push is accepted.
REQ-020 evt_code/evt_repeat hold stable while evt_valid=1 and evt_ready=0.
REQ-021 The repeat FSM has states IDLE, HOLD, REPEAT, a 3-bit active key register and a tick counter wide enough for max(REPEAT_DELAY, REPEAT_RATE).
REQ-022 Any enqueued key_pulse: go to HOLD, latch the key, clear the counter (from any state, including a different key).
REQ-023 HOLD: each tick increments the counter; at REPEAT_DELAY, enqueue {key, repeat=1}, clear the counter and go to REPEAT.
REQ-024 REPEAT: each tick increments the counter; at REPEAT_RATE, enqueue {key, repeat=1} and clear the counter.
REQ-025 HOLD/REPEAT: key_level[key]=0 gives IDLE with no enqueue that cycle; release has priority over a tick in the same cycle.
REQ-026 A repeat enqueue coinciding with a key_pulse enqueue is discarded silently (no overflow); the key_pulse rule applies.
REQ-027 A repeat event dropped because the FIFO is full sets overflow; the FSM continues timing.
REQ-028 ovf_clr and a new overflow in the same cycle leave overflow=1.

Reset
REQ-029 On reset: FIFO emptied, fifo_count=0, evt_valid=0, evt_code=0, evt_repeat=0, overflow=0, FSM=IDLE, counter=0.
REQ-030 Reset mid-operation discards all queued events and any hold timing; the first press after reset starts fresh.

Structure
REQ-031 A shared package holds KEY_W=3, the event record {code[2:0], repeat}, and the FSM state encoding.
REQ-032 One sub-module, event_fifo: synchronous show-ahead FIFO parameterised by DEPTH and width, with push/pop/full/empty/count outputs.

Verification
REQ-033 Pulse key 2 once with key_level low, evt_ready=1 -> exactly one event, code=2, repeat=0, in cycle N+1.
REQ-034 Pulse key 1 and hold level 40 ticks, defaults -> press plus repeats at tick 16, 20, 24, ..., 40 (7 repeats), then none after release.
REQ-035 evt_ready=0, 5 distinct presses -> fifo_count=4, overflow=1, the 5th is lost, and draining returns presses 1..4 in order.
REQ-036 key_pulse=5'b10110 in one cycle -> single event code=1 and overflow=1.
REQ-037 Hold key 0 into REPEAT, then pulse key 3 -> events switch to key 3, with its first repeat 16 ticks later.
REQ-038 Assert reset with 3 queued events and in REPEAT state -> the next cycle shows evt_valid=0, fifo_count=0, overflow=0, and no repeats follow.

Source files
------------

// File: rtl/key_event_sequencer_pkg.sv
// Shared types for the key event sequencer: event record, repeat FSM states
// and the lowest-index key selector.
package key_event_sequencer_pkg;

    localparam int KEY_W    = 3;
    localparam int NUM_KEYS = 5;
    localparam int EVT_W    = KEY_W + 1;

    typedef struct packed {
        logic [KEY_W-1:0] code;
        logic             rpt;
    } evt_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    // Lowest set index wins when several keys pulse together.
    function automatic logic [KEY_W-1:0] lowest_key(input logic [NUM_KEYS-1:0] pulses);
        lowest_key = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pulses[i]) lowest_key = KEY_W'(i);
        end
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on pop_data whenever
// the FIFO is not empty. A push to a full FIFO is accepted only if a pop occurs.
module event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                       sysclk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: every signal gets a default at the top of an always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together at the edge regardless of statement order.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; entries are only read while
    // count says they are valid, and the empty case is forced to zero below.
    always_ff @(posedge sysclk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/key_event_sequencer.sv
// Turns key press pulses and held levels into a queue of press and
// auto-repeat events, with a sticky overflow flag for dropped events.
module key_event_sequencer
    import key_event_sequencer_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4
) (
    input  logic                      sysclk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic [NUM_KEYS-1:0]       key_pulse,
    input  logic [NUM_KEYS-1:0]       key_level,
    input  logic                      evt_ready,
    output logic                      evt_valid,
    output logic [KEY_W-1:0]          evt_code,
    output logic                      evt_repeat,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      overflow,
    input  logic                      ovf_clr
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    rpt_state_e       state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc, cnt_limit;
    logic             overflow_q, overflow_d;

    logic             pulse_any, pulse_multi, key_held, rpt_fire;
    logic             push, pop, full, empty;
    evt_t             push_evt, head_evt;

    assign pulse_any   = |key_pulse;
    assign pulse_multi = (key_pulse & (key_pulse - NUM_KEYS'(1))) != '0;
    assign key_held    = key_level[key_q];
    assign cnt_inc     = cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        cnt_d     = cnt_q;
        rpt_fire  = 1'b0;
        cnt_limit = (state_q == ST_HOLD) ? CNT_W'(REPEAT_DELAY) : CNT_W'(REPEAT_RATE);
        // A press always restarts hold timing, even for a different key, and
        // suppresses any repeat that would have fired this cycle.
        if (pulse_any) begin
            state_d = ST_HOLD;
            key_d   = lowest_key(key_pulse);
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_HOLD, ST_REPEAT: begin
                    if (!key_held) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (tick) begin
                        if (cnt_inc == cnt_limit) begin
                            rpt_fire = 1'b1;
                            cnt_d    = '0;
                            state_d  = ST_REPEAT;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        push          = pulse_any || rpt_fire;
        push_evt.code = pulse_any ? lowest_key(key_pulse) : key_q;
        push_evt.rpt  = !pulse_any;
        pop           = evt_ready && !empty;
        // Clear loses to a fresh drop in the same cycle.
        overflow_d    = (overflow_q && !ovf_clr) || pulse_multi || (push && full && !pop);
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EVT_W)
    ) u_event_fifo (
        .sysclk    (sysclk),
        .reset     (reset),
        .push      (push),
        .push_data (push_evt),
        .pop       (pop),
        .pop_data  (head_evt),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    assign evt_valid  = !empty;
    assign evt_code   = head_evt.code;
    assign evt_repeat = head_evt.rpt;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_key_event_sequencer.sv
// Directed bench for key_event_sequencer: expected events are queued as
// stimulus is driven and compared as the consumer pops them.
module tb_key_event_sequencer;
    import key_event_sequencer_pkg::*;

    logic       sysclk = 1'b0;
    logic       reset, tick, evt_ready, ovf_clr;
    logic [4:0] key_pulse, key_level;
    logic       evt_valid, evt_repeat, overflow;
    logic [2:0] evt_code;
    logic [2:0] fifo_count;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    evt_t exp_q[$];

    always #5 sysclk = ~sysclk;

    key_event_sequencer dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .tick       (tick),
        .key_pulse  (key_pulse),
        .key_level  (key_level),
        .evt_ready  (evt_ready),
        .evt_valid  (evt_valid),
        .evt_code   (evt_code),
        .evt_repeat (evt_repeat),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read then
    // or at the falling edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic tick_once();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(3);
    endtask

    task automatic expect_evt(input int code, input logic rpt);
        evt_t e;
        e.code = 3'(code);
        e.rpt  = rpt;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) cyc(1);
        cyc(1);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_valid"}, evt_valid, 1'b0);
    endtask

    // Consumer side: every handshake must match the oldest expected event.
    always @(negedge sysclk) begin
        if (reset === 1'b0 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            evt_t e;
            check("evt_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("evt_code", evt_code, e.code);
                check("evt_repeat", evt_repeat, e.rpt);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        tick      = 1'b0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        key_pulse = '0;
        key_level = '0;
        cyc(3);
        check("rst_valid", evt_valid, 1'b0);
        check("rst_count", fifo_count, 3'd0);
        check("rst_code", evt_code, 3'd0);
        check("rst_repeat", evt_repeat, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        reset = 1'b0;
        cyc(1);

        // Single press, key released: one event in the next cycle.
        evt_ready = 1'b1;
        key_pulse = 5'b00100;
        expect_evt(2, 1'b0);
        check("p1_pre_valid", evt_valid, 1'b0);
        cyc(1);
        key_pulse = '0;
        check("p1_valid_n1", evt_valid, 1'b1);
        check("p1_code_n1", evt_code, 3'd2);
        check("p1_repeat_n1", evt_repeat, 1'b0);
        cyc(1);
        check("p1_single", evt_valid, 1'b0);
        wait_drain("p1");

        // Hold key 1 for 40 ticks: repeats at ticks 16, 20, ..., 40.
        key_level = 5'b00010;
        key_pulse = 5'b00010;
        expect_evt(1, 1'b0);
        cyc(1);
        key_pulse = '0;
        cyc(2);
        for (int i = 1; i <= 40; i++) begin
            if (i >= 16 && (i - 16) % 4 == 0) expect_evt(1, 1'b1);
            tick_once();
        end
        key_level = '0;
        for (int i = 0; i < 12; i++) tick_once();
        wait_drain("p2");
        check("p2_count", fifo_count, 3'd0);

        // Stalled consumer: four presses fill the FIFO, the fifth is lost.
        evt_ready = 1'b0;
        check("p3_ovf_before", overflow, 1'b0);
        for (int k = 0; k < 5; k++) begin
            key_pulse = 5'(1 << k);
            if (k < 4) expect_evt(k, 1'b0);
            cyc(1);
            key_pulse = '0;
            check("p3_count", fifo_count, (k < 4) ? k + 1 : 4);
            check("p3_overflow", overflow, (k == 4) ? 1'b1 : 1'b0);
            check("p3_head_stable", evt_code, 3'd0);
        end
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        check("p3_ovf_cleared", overflow, 1'b0);
        // Push into a full FIFO alongside a pop is accepted.
        evt_ready = 1'b1;
        key_pulse = 5'b10000;
        expect_evt(4, 1'b0);
        cyc(1);
        key_pulse = '0;
        evt_ready = 1'b0;
        check("p3_full_pushpop_count", fifo_count, 3'd4);
        check("p3_full_pushpop_ovf", overflow, 1'b0);
        evt_ready = 1'b1;
        wait_drain("p3");

        // Simultaneous pulses, and clear racing a new overflow.
        key_pulse = 5'b10110;
        expect_evt(1, 1'b0);
        cyc(1);
        key_pulse = '0;
        check("p4_multi_ovf", overflow, 1'b1);
        ovf_clr   = 1'b1;
        key_pulse = 5'b00011;
        expect_evt(0, 1'b0);
        cyc(1);
        ovf_clr   = 1'b0;
        key_pulse = '0;
        check("p4_clr_vs_set", overflow, 1'b1);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        check("p4_clr", overflow, 1'b0);
        wait_drain("p4");

        // Key 0 repeating, then key 3 pressed: timing restarts for key 3.
        key_level = 5'b00001;
        key_pulse = 5'b00001;
        expect_evt(0, 1'b0);
        cyc(1);
        key_pulse = '0;
        cyc(2);
        for (int i = 1; i <= 18; i++) begin
            if (i == 16) expect_evt(0, 1'b1);
            tick_once();
        end
        key_level = 5'b01001;
        key_pulse = 5'b01000;
        expect_evt(3, 1'b0);
        cyc(1);
        key_pulse = '0;
        cyc(2);
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) expect_evt(3, 1'b1);
            tick_once();
        end
        key_level = '0;
        for (int i = 0; i < 6; i++) tick_once();
        wait_drain("p5");

        // Reset with three queued events while repeating.
        evt_ready = 1'b0;
        key_level = 5'b00010;
        key_pulse = 5'b00110;
        cyc(1);
        key_pulse = '0;
        check("p6_ovf_set", overflow, 1'b1);
        cyc(2);
        for (int i = 0; i < 20; i++) tick_once();
        check("p6_queued", fifo_count, 3'd3);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("p6_rst_valid", evt_valid, 1'b0);
        check("p6_rst_count", fifo_count, 3'd0);
        check("p6_rst_overflow", overflow, 1'b0);
        check("p6_rst_code", evt_code, 3'd0);
        check("p6_rst_repeat", evt_repeat, 1'b0);
        evt_ready = 1'b1;
        for (int i = 0; i < 30; i++) tick_once();
        check("p6_no_repeat_count", fifo_count, 3'd0);
        check("p6_no_repeat_valid", evt_valid, 1'b0);
        check("p6_no_repeat_pending", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
